odp_writer: RTL and testbench

- Output data processor: the write-side counterpart of the input data processor.
- Accepts a stream of 16-bit result pixels from the compute array and packs two pixels per 32-bit word.
- Buffers the words in an internal FIFO and writes them to external RAM through the shared RAM controller as bursts of 1-16 words, starting at a configured address.
- Sits beside the input data processor on the same controller; the controller arbitrates between them.

---
 rtl/odp_writer.sv | 203 ++++++++++++++++++++
 tb/tb_odp_writer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/odp_writer.sv
// Output data processor: packs 16-bit result pixels two-per-word into a FIFO and
// writes them to external RAM as bursts of up to BURST_LEN words through the RAM controller.
module odp_writer #(
    parameter int FIFO_DEPTH = 32,
    parameter int BURST_LEN  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        px_in_vld,
    input  logic [15:0] px_in,
    output logic        px_in_rdy,
    output logic        MEM_REQ,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_CMD,
    output logic        MEM_WE,
    output logic [31:0] MEM_DOUT,
    output logic        MEM_WVLD,
    input  logic        MEM_WRDY,
    input  logic        MEM_ODP_SEL,
    input  logic        MEM_FIN,
    input  logic        ODP_START,
    output logic        ODP_STATUS,
    input  logic [31:0] CFG_WRITE_START_ADDR,
    input  logic [8:0]  CFG_WIDTH,
    input  logic [8:0]  CFG_HEIGHT,
    input  logic [9:0]  CFG_NUM_FMAP
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Handshakes: a pixel moves on px_in_vld & px_in_rdy, a word moves on
    // MEM_WVLD & MEM_WRDY; both sides sample on the rising clock edge.
    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_FILL, S_REQ, S_DATA, S_WAIT_FIN, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          status_q, status_d;
    logic [31:0]   addr_q, addr_d;
    logic [27:0]   p_q, p_d;
    logic [26:0]   t_q, t_d;
    logic [26:0]   w_done_q, w_done_d;
    logic [27:0]   px_cnt_q, px_cnt_d;
    logic          half_q, half_d;
    logic [15:0]   hold_q, hold_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    pop_cnt_q, pop_cnt_d;
    logic [31:0]   mem_q [FIFO_DEPTH];

    logic          fifo_full, fifo_empty, px_xfer, push, pop, job_start, mem_req;
    logic [31:0]   push_data;
    logic [26:0]   words_left;
    logic [4:0]    burst_len;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign px_in_rdy  = status_q && !fifo_full && (px_cnt_q < p_q);
    assign px_xfer    = px_in_vld && px_in_rdy;
    assign job_start  = (state_q == S_IDLE) && ODP_START;

    assign words_left = t_q - w_done_q;
    assign burst_len  = (words_left < 27'(BURST_LEN)) ? words_left[4:0] : 5'(BURST_LEN);

    assign mem_req    = (state_q == S_REQ) || (state_q == S_DATA) || (state_q == S_WAIT_FIN);
    assign MEM_REQ    = mem_req;
    assign MEM_WE     = mem_req;
    assign MEM_ADDR   = mem_req ? (addr_q + {3'b000, w_done_q, 2'b00}) : 32'h0;
    assign MEM_CMD    = mem_req ? 4'(burst_len - 5'd1) : 4'h0;
    assign MEM_WVLD   = (state_q == S_DATA) && !fifo_empty;
    assign MEM_DOUT   = MEM_WVLD ? mem_q[rd_ptr_q] : 32'h0;
    assign ODP_STATUS = status_q;
    assign pop        = MEM_WVLD && MEM_WRDY;

    // Pixel packing: even pixel waits in hold_q, odd pixel completes the word.
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        half_d    = half_q;
        hold_d    = hold_q;
        px_cnt_d  = px_cnt_q;
        if (job_start) begin
            px_cnt_d = '0;
            half_d   = 1'b0;
        end else if (px_xfer) begin
            px_cnt_d = px_cnt_q + 28'd1;
            if (half_q) begin
                push      = 1'b1;
                push_data = {px_in, hold_q};
                half_d    = 1'b0;
            end else if (px_cnt_q == p_q - 28'd1) begin
                push      = 1'b1;
                push_data = {16'h0000, px_in};
            end else begin
                hold_d = px_in;
                half_d = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        addr_d    = addr_q;
        p_d       = p_q;
        t_d       = t_q;
        w_done_d  = w_done_q;
        pop_cnt_d = pop_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ODP_START) begin
                    p_d      = 28'(CFG_WIDTH) * 28'(CFG_HEIGHT) * 28'(CFG_NUM_FMAP);
                    addr_d   = CFG_WRITE_START_ADDR;
                    w_done_d = '0;
                    // An empty job never leaves IDLE.
                    if (p_d != 28'd0) begin
                        state_d  = S_CALC;
                        status_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                t_d     = p_q[27:1] + 27'(p_q[0]);
                state_d = S_FILL;
            end
            S_FILL: begin
                if (count_q >= CW'(burst_len)) begin
                    pop_cnt_d = '0;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (MEM_ODP_SEL) state_d = S_DATA;
            end
            S_DATA: begin
                if (pop) begin
                    pop_cnt_d = pop_cnt_q + 5'd1;
                    if (pop_cnt_d == burst_len) state_d = S_WAIT_FIN;
                end
            end
            S_WAIT_FIN: begin
                if (MEM_FIN) begin
                    w_done_d = w_done_q + 27'(burst_len);
                    state_d  = (w_done_d < t_q) ? S_FILL : S_DONE;
                end
            end
            S_DONE: begin
                status_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            status_q  <= 1'b0;
            addr_q    <= '0;
            p_q       <= '0;
            t_q       <= '0;
            w_done_q  <= '0;
            px_cnt_q  <= '0;
            half_q    <= 1'b0;
            hold_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pop_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            addr_q    <= addr_d;
            p_q       <= p_d;
            t_q       <= t_d;
            w_done_q  <= w_done_d;
            px_cnt_q  <= px_cnt_d;
            half_q    <= half_d;
            hold_q    <= hold_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pop_cnt_q <= pop_cnt_d;
        end
    end

    // Storage array needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: tb/tb_odp_writer.sv
// Bench for odp_writer: table of jobs driven through a pixel source and a RAM-controller
// responder, with a word scoreboard and hand-written sequences for empty job and mid-burst reset.
module tb_odp_writer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        px_in_vld = 1'b0;
    logic [15:0] px_in = '0;
    logic        px_in_rdy;
    logic        MEM_REQ, MEM_WE, MEM_WVLD, ODP_STATUS;
    logic [31:0] MEM_ADDR, MEM_DOUT;
    logic [3:0]  MEM_CMD;
    logic        MEM_WRDY = 1'b0, MEM_ODP_SEL = 1'b0, MEM_FIN = 1'b0, ODP_START = 1'b0;
    logic [31:0] CFG_WRITE_START_ADDR = '0;
    logic [8:0]  CFG_WIDTH = '0, CFG_HEIGHT = '0;
    logic [9:0]  CFG_NUM_FMAP = '0;

    odp_writer #(.FIFO_DEPTH(32), .BURST_LEN(16)) dut (
        .clk(clk), .rst_n(rst_n), .px_in_vld(px_in_vld), .px_in(px_in), .px_in_rdy(px_in_rdy),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_CMD(MEM_CMD), .MEM_WE(MEM_WE),
        .MEM_DOUT(MEM_DOUT), .MEM_WVLD(MEM_WVLD), .MEM_WRDY(MEM_WRDY),
        .MEM_ODP_SEL(MEM_ODP_SEL), .MEM_FIN(MEM_FIN), .ODP_START(ODP_START),
        .ODP_STATUS(ODP_STATUS), .CFG_WRITE_START_ADDR(CFG_WRITE_START_ADDR),
        .CFG_WIDTH(CFG_WIDTH), .CFG_HEIGHT(CFG_HEIGHT), .CFG_NUM_FMAP(CFG_NUM_FMAP)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  w;
        logic [8:0]  h;
        logic [9:0]  n;
        logic [31:0] addr;
        int          base;
        bit          rand_wrdy;
        int          grant_dly;
        bit          px_gaps;
        bit          restart_mid;
        bit          early_fin;
        int          exp_t;
        int          exp_bursts;
        logic [3:0]  exp_last_cmd;
        bit          exp_stall;
    } job_t;

    job_t        jobs[6];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_job(input job_t j);
        @(negedge clk);
        CFG_WIDTH = j.w; CFG_HEIGHT = j.h; CFG_NUM_FMAP = j.n; CFG_WRITE_START_ADDR = j.addr;
        ODP_START = 1'b1;
        @(negedge clk);
        ODP_START = 1'b0;
    endtask

    task automatic drive_pixels(input job_t j, output bit stall);
        int p = int'(j.w) * int'(j.h) * int'(j.n);
        int i = 0;
        int cyc = 0;
        bit restarted = 0;
        stall = 0;
        while (i < p && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            ODP_START = 1'b0;
            if (j.restart_mid && i == 5 && !restarted) begin
                // Busy-time START with a different config must change nothing.
                restarted = 1;
                CFG_WIDTH = 9'd1; CFG_HEIGHT = 9'd1; CFG_NUM_FMAP = 10'd1;
                CFG_WRITE_START_ADDR = 32'hDEAD_0000;
                ODP_START = 1'b1;
            end
            px_in_vld = j.px_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            px_in = 16'(j.base + i);
            if (px_in_vld && !px_in_rdy) stall = 1;
            if (px_in_vld && px_in_rdy) i++;
        end
        @(negedge clk);
        ODP_START = 1'b0;
        px_in_vld = 1'b0;
        check("px_count_reached", 32'(i), 32'(p));
        check("rdy_low_after_last_px", {31'b0, px_in_rdy}, 32'h0);
    endtask

    task automatic respond(input job_t j, input int t_words, output int bursts, output int words,
                           output logic [3:0] last_cmd);
        int wdone = 0;
        bursts = 0; words = 0; last_cmd = '0;
        while (wdone < t_words) begin
            int b = (t_words - wdone < 16) ? (t_words - wdone) : 16;
            int cyc = 0;
            int got = 0;
            bit first = 1;
            logic [31:0] exp_addr = j.addr + 32'(4 * wdone);
            while (!MEM_REQ && cyc < 3000) begin
                @(negedge clk);
                cyc++;
            end
            if (!MEM_REQ) begin
                check("req_timeout", 32'h0, 32'h1);
                return;
            end
            check("burst_addr", MEM_ADDR, exp_addr);
            check("burst_cmd", {28'b0, MEM_CMD}, 32'(b - 1));
            check("burst_we", {31'b0, MEM_WE}, 32'h1);
            for (int k = 0; k < j.grant_dly; k++) begin
                @(negedge clk);
                check("addr_stable_pre_grant", MEM_ADDR, exp_addr);
                check("cmd_stable_pre_grant", {28'b0, MEM_CMD}, 32'(b - 1));
            end
            MEM_ODP_SEL = 1'b1;
            cyc = 0;
            while (got < b && cyc < 3000) begin
                @(negedge clk);
                cyc++;
                MEM_FIN = j.early_fin && first;
                first = 0;
                MEM_WRDY = j.rand_wrdy ? ($urandom_range(0, 3) == 0) : 1'b1;
                if (MEM_WVLD && MEM_WRDY) begin
                    got++;
                    if (exp_q.size() == 0) check("extra_word", MEM_DOUT, 32'hFFFF_FFFF);
                    else check("word_data", MEM_DOUT, exp_q.pop_front());
                end
            end
            if (got < b) check("data_timeout", 32'(got), 32'(b));
            @(negedge clk);
            MEM_FIN = 1'b0;
            MEM_WRDY = 1'b0;
            if (j.early_fin) MEM_ODP_SEL = 1'b0;
            check("wvld_low_wait_fin", {31'b0, MEM_WVLD}, 32'h0);
            check("req_held_wait_fin", {31'b0, MEM_REQ}, 32'h1);
            MEM_FIN = 1'b1;
            @(negedge clk);
            MEM_FIN = 1'b0;
            MEM_ODP_SEL = 1'b0;
            check("req_drop_after_fin", {31'b0, MEM_REQ}, 32'h0);
            bursts++;
            words += got;
            last_cmd = 4'(b - 1);
            wdone += b;
        end
    endtask

    task automatic run_job(input string tag, input job_t j);
        int p = int'(j.w) * int'(j.h) * int'(j.n);
        int t_words = (p + 1) / 2;
        int bursts, words, cyc;
        logic [3:0] last_cmd;
        bit stall;
        exp_q.delete();
        for (int k = 0; k < t_words; k++) begin
            logic [15:0] lo = 16'(j.base + 2 * k);
            logic [15:0] hi = (2 * k + 1 < p) ? 16'(j.base + 2 * k + 1) : 16'h0000;
            exp_q.push_back({hi, lo});
        end
        start_job(j);
        check({tag, "_status_rise"}, {31'b0, ODP_STATUS}, 32'h1);
        fork
            drive_pixels(j, stall);
            respond(j, t_words, bursts, words, last_cmd);
        join
        cyc = 0;
        while (ODP_STATUS && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_status_fall"}, {31'b0, ODP_STATUS}, 32'h0);
        check({tag, "_words"}, 32'(words), 32'(j.exp_t));
        check({tag, "_bursts"}, 32'(bursts), 32'(j.exp_bursts));
        check({tag, "_last_cmd"}, {28'b0, last_cmd}, {28'b0, j.exp_last_cmd});
        check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'h0);
        check({tag, "_stall_seen"}, {31'b0, stall}, {31'b0, j.exp_stall});
    endtask

    initial begin
        bit dummy_stall;
        int cyc;
        //          w  h  n  addr           base      rw dly gap rst efin T  B  last   stall
        jobs[0] = '{9'd4, 9'd2, 10'd1, 32'h0000_1000, 0,       0, 0,  0, 0, 0,  4, 1, 4'd3,  0};
        jobs[1] = '{9'd3, 9'd1, 10'd1, 32'h0000_3000, 0,       0, 0,  0, 0, 0,  2, 1, 4'd1,  0};
        jobs[2] = '{9'd8, 9'd5, 10'd1, 32'h0000_2000, 'h100,   0, 0,  0, 0, 0, 20, 2, 4'd3,  0};
        jobs[3] = '{9'd16, 9'd8, 10'd1, 32'h0000_4000, 'h5000, 1, 10, 0, 0, 1, 64, 4, 4'd15, 1};
        jobs[4] = '{9'd7, 9'd3, 10'd3, 32'hFFFF_FFC0, 'hFFF0,  0, 2,  1, 1, 0, 32, 2, 4'd15, 0};
        jobs[5] = '{9'd4, 9'd2, 10'd1, 32'h0000_1000, 0,       0, 0,  0, 0, 0,  4, 1, 4'd3,  0};

        repeat (3) @(negedge clk);
        check("reset_ctl", {23'b0, MEM_REQ, MEM_WE, MEM_WVLD, ODP_STATUS, px_in_rdy, MEM_CMD}, 32'h0);
        check("reset_addr", MEM_ADDR, 32'h0);
        check("reset_dout", MEM_DOUT, 32'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) run_job($sformatf("job%0d", k), jobs[k]);

        // Empty job: W=0 must leave the block idle.
        start_job('{9'd0, 9'd5, 10'd1, 32'h0000_8000, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0});
        for (int k = 0; k < 5; k++) begin
            check("zero_job_idle", {29'b0, ODP_STATUS, MEM_REQ, px_in_rdy}, 32'h0);
            @(negedge clk);
        end

        // Reset in the middle of a data phase, then a clean job.
        exp_q.delete();
        start_job(jobs[0]);
        drive_pixels(jobs[0], dummy_stall);
        cyc = 0;
        while (!MEM_REQ && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        MEM_ODP_SEL = 1'b1;
        MEM_WRDY = 1'b0;
        @(negedge clk);
        check("in_data_before_reset", {31'b0, MEM_WVLD}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ctl", {23'b0, MEM_REQ, MEM_WE, MEM_WVLD, ODP_STATUS, px_in_rdy, MEM_CMD}, 32'h0);
        check("async_reset_addr", MEM_ADDR, 32'h0);
        check("async_reset_dout", MEM_DOUT, 32'h0);
        @(negedge clk);
        MEM_ODP_SEL = 1'b0;
        rst_n = 1'b1;
        run_job("job_after_reset", jobs[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
